// File: rtl/rv_load_store.sv
// Memory-access stage of the uRV pipeline: turns one execute op into a data-bus
// load/store (byte lanes, aligned address) or passes an ALU result to writeback.
module rv_load_store #(
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        e_valid_i,
  output logic        e_ready_o,
  input  logic        e_load_i,
  input  logic        e_store_i,
  input  logic [2:0]  e_fun_i,
  input  logic [31:0] e_addr_i,
  input  logic [31:0] e_store_data_i,
  input  logic [4:0]  e_rd_i,
  input  logic [31:0] e_rd_value_i,
  input  logic        e_rd_write_i,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_data_s_o,
  output logic [3:0]  dm_data_select_o,
  output logic        dm_load_o,
  output logic        dm_store_o,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic [2:0]  x_fun_o,
  output logic        x_load_o,
  output logic [31:0] x_dm_addr_o,
  output logic [4:0]  x_rd_o,
  output logic [31:0] x_rd_value_o,
  output logic        x_rd_write_o,
  output logic        w_stall_o,
  output logic        x_misaligned_o,
  output logic        x_bus_error_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_LOAD,
    S_WAIT_STORE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_cnt;

  logic        w_accept;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_done;
  logic        w_timeout;
  logic [3:0]  w_sel;
  logic [31:0] w_sdata;

  assign e_ready_o = (r_state == S_IDLE);
  assign w_stall_o = (r_state != S_IDLE) && !w_done;

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = e_valid_i && (r_state == S_IDLE);
    // A simultaneous load+store request resolves to a load.
    w_is_load    = e_load_i;
    w_is_store   = e_store_i && !e_load_i;
    w_mem_op     = w_is_load || w_is_store;
    w_misaligned = ((e_fun_i[1:0] == 2'b01) && e_addr_i[0]) ||
                   ((e_fun_i[1:0] == 2'b10) && (e_addr_i[1:0] != 2'b00));
    w_done       = ((r_state == S_WAIT_LOAD)  && dm_load_done_i) ||
                   ((r_state == S_WAIT_STORE) && dm_store_done_i);
    w_timeout    = (WAIT_TIMEOUT != 0) && (r_state != S_IDLE) && !w_done &&
                   (r_cnt == 32'(WAIT_TIMEOUT - 1));
    w_sel        = 4'b1111;
    w_sdata      = e_store_data_i;

    case (e_fun_i[1:0])
      2'b00: begin
        w_sel   = 4'b0001 << e_addr_i[1:0];
        w_sdata = {4{e_store_data_i[7:0]}};
      end
      2'b01: begin
        w_sel   = e_addr_i[1] ? 4'b1100 : 4'b0011;
        w_sdata = {2{e_store_data_i[15:0]}};
      end
      default: begin
        w_sel   = 4'b1111;
        w_sdata = e_store_data_i;
      end
    endcase

    case (r_state)
      S_IDLE: begin
        if (w_accept && w_mem_op && !w_misaligned)
          w_state_next = w_is_load ? S_WAIT_LOAD : S_WAIT_STORE;
      end
      default: begin
        if (w_done || w_timeout)
          w_state_next = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt            <= '0;
      dm_addr_o        <= '0;
      dm_data_s_o      <= '0;
      dm_data_select_o <= '0;
      dm_load_o        <= 1'b0;
      dm_store_o       <= 1'b0;
      x_fun_o          <= '0;
      x_load_o         <= 1'b0;
      x_dm_addr_o      <= '0;
      x_rd_o           <= '0;
      x_rd_value_o     <= '0;
      x_rd_write_o     <= 1'b0;
      x_misaligned_o   <= 1'b0;
      x_bus_error_o    <= 1'b0;
    end else begin
      dm_load_o      <= 1'b0;
      dm_store_o     <= 1'b0;
      x_misaligned_o <= 1'b0;
      x_bus_error_o  <= w_timeout;

      case (r_state)
        S_IDLE: begin
          if (!w_accept) begin
            x_load_o     <= 1'b0;
            x_rd_write_o <= 1'b0;
          end else if (!w_mem_op) begin
            x_fun_o      <= e_fun_i;
            x_rd_o       <= e_rd_i;
            x_rd_value_o <= e_rd_value_i;
            x_rd_write_o <= e_rd_write_i;
            x_load_o     <= 1'b0;
          end else if (w_misaligned) begin
            x_misaligned_o <= 1'b1;
            x_load_o       <= 1'b0;
            x_rd_write_o   <= 1'b0;
          end else begin
            r_cnt        <= '0;
            dm_addr_o    <= {e_addr_i[31:2], 2'b00};
            x_fun_o      <= e_fun_i;
            x_dm_addr_o  <= e_addr_i;
            x_rd_o       <= e_rd_i;
            x_rd_write_o <= 1'b0;
            x_load_o     <= w_is_load;
            if (w_is_load) begin
              dm_load_o        <= 1'b1;
              dm_data_select_o <= 4'b1111;
            end else begin
              dm_store_o       <= 1'b1;
              dm_data_select_o <= w_sel;
              dm_data_s_o      <= w_sdata;
            end
          end
        end
        default: begin
          if (w_done || w_timeout) x_load_o <= 1'b0;
          else                     r_cnt    <= r_cnt + 32'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_load_store.sv
// Scoreboard bench for rv_load_store: each driven op pushes its expected bus/x_*
// response, which is popped and compared when the stage answers.
module tb_rv_load_store;

  typedef enum {K_ALU, K_LOAD, K_STORE, K_MIS} kind_e;

  typedef struct {
    kind_e       kind;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        e_valid_i, e_load_i, e_store_i, e_rd_write_i;
  logic [2:0]  e_fun_i;
  logic [31:0] e_addr_i, e_store_data_i, e_rd_value_i;
  logic [4:0]  e_rd_i;
  logic        e_ready_o;
  logic [31:0] dm_addr_o, dm_data_s_o;
  logic [3:0]  dm_data_select_o;
  logic        dm_load_o, dm_store_o, dm_load_done_i, dm_store_done_i;
  logic [2:0]  x_fun_o;
  logic        x_load_o, x_rd_write_o, w_stall_o, x_misaligned_o, x_bus_error_o;
  logic [31:0] x_dm_addr_o, x_rd_value_o;
  logic [4:0]  x_rd_o;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  rv_load_store #(.WAIT_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .e_valid_i(e_valid_i), .e_ready_o(e_ready_o),
    .e_load_i(e_load_i), .e_store_i(e_store_i), .e_fun_i(e_fun_i),
    .e_addr_i(e_addr_i), .e_store_data_i(e_store_data_i),
    .e_rd_i(e_rd_i), .e_rd_value_i(e_rd_value_i), .e_rd_write_i(e_rd_write_i),
    .dm_addr_o(dm_addr_o), .dm_data_s_o(dm_data_s_o),
    .dm_data_select_o(dm_data_select_o),
    .dm_load_o(dm_load_o), .dm_store_o(dm_store_o),
    .dm_load_done_i(dm_load_done_i), .dm_store_done_i(dm_store_done_i),
    .x_fun_o(x_fun_o), .x_load_o(x_load_o), .x_dm_addr_o(x_dm_addr_o),
    .x_rd_o(x_rd_o), .x_rd_value_o(x_rd_value_o), .x_rd_write_o(x_rd_write_o),
    .w_stall_o(w_stall_o), .x_misaligned_o(x_misaligned_o),
    .x_bus_error_o(x_bus_error_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] fun,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic [31:0] val, input logic wr,
                          input kind_e kind, input logic [3:0] sel, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.rd   = rd;
    e.val  = val;
    e.addr = addr;
    e.sel  = sel;
    e.data = data;
    sb.push_back(e);
    e_valid_i = 1'b1; e_load_i = ld; e_store_i = st; e_fun_i = fun;
    e_addr_i = addr; e_store_data_i = sdata; e_rd_i = rd;
    e_rd_value_i = val; e_rd_write_i = wr;
    tick();
    e_valid_i = 1'b0; e_load_i = 1'b0; e_store_i = 1'b0; e_rd_write_i = 1'b0;
  endtask

  task automatic expect_resp(input string tag);
    exp_t e;
    int   waited = 0;
    while (!(dm_load_o || dm_store_o || x_misaligned_o || x_rd_write_o) && waited < 4) begin
      tick();
      waited++;
    end
    if (!(dm_load_o || dm_store_o || x_misaligned_o || x_rd_write_o)) begin
      check({tag, "_no_response"}, 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_dm_load"},  32'(dm_load_o),      32'(e.kind == K_LOAD));
    check({tag, "_dm_store"}, 32'(dm_store_o),     32'(e.kind == K_STORE));
    check({tag, "_mis"},      32'(x_misaligned_o), 32'(e.kind == K_MIS));
    check({tag, "_x_load"},   32'(x_load_o),       32'(e.kind == K_LOAD));
    check({tag, "_rd_write"}, 32'(x_rd_write_o),   32'(e.kind == K_ALU));
    check({tag, "_ready"},    32'(e_ready_o),      32'(e.kind == K_ALU || e.kind == K_MIS));
    check({tag, "_stall"},    32'(w_stall_o),      32'(e.kind == K_LOAD || e.kind == K_STORE));
    if (e.kind == K_ALU) begin
      check({tag, "_x_rd"},     32'(x_rd_o),  32'(e.rd));
      check({tag, "_x_value"},  x_rd_value_o, e.val);
    end
    if (e.kind == K_LOAD || e.kind == K_STORE) begin
      check({tag, "_dm_addr"}, dm_addr_o,   {e.addr[31:2], 2'b00});
      check({tag, "_sel"},     32'(dm_data_select_o), 32'(e.sel));
      check({tag, "_x_addr"},  x_dm_addr_o, e.addr);
      check({tag, "_x_rd"},    32'(x_rd_o), 32'(e.rd));
    end
    if (e.kind == K_STORE) check({tag, "_sdata"}, dm_data_s_o, e.data);
  endtask

  initial begin
    int n_stall;
    int n_wait;
    rst_i = 1'b1;
    e_valid_i = 1'b0; e_load_i = 1'b0; e_store_i = 1'b0; e_fun_i = '0;
    e_addr_i = '0; e_store_data_i = '0; e_rd_i = '0; e_rd_value_i = '0; e_rd_write_i = 1'b0;
    dm_load_done_i = 1'b0; dm_store_done_i = 1'b0;
    tick();
    tick();
    check("rst_ready",    32'(e_ready_o), 32'd1);
    check("rst_dm_load",  32'(dm_load_o), 32'd0);
    check("rst_dm_store", 32'(dm_store_o), 32'd0);
    check("rst_dm_addr",  dm_addr_o, 32'd0);
    check("rst_sel",      32'(dm_data_select_o), 32'd0);
    check("rst_x_value",  x_rd_value_o, 32'd0);
    check("rst_x_load",   32'(x_load_o), 32'd0);
    check("rst_stall",    32'(w_stall_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // ALU op, then a bubble clears the write enable but holds the value.
    drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd5, 32'h0000_1234, 1'b1, K_ALU, 4'h0, 32'h0);
    expect_resp("alu");
    tick();
    check("bubble_rd_write", 32'(x_rd_write_o), 32'd0);
    check("bubble_value",    x_rd_value_o, 32'h0000_1234);

    // LB 0x1003: done two cycles after the request pulse; wrong-kind done ignored.
    n_stall = 0;
    drive_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd3, 32'h0, 1'b0, K_LOAD, 4'b1111, 32'h0);
    expect_resp("lb");
    if (w_stall_o) n_stall++;
    tick();
    check("lb_pulse_end", 32'(dm_load_o), 32'd0);
    check("lb_ready_low", 32'(e_ready_o), 32'd0);
    dm_store_done_i = 1'b1;
    #1;
    check("lb_wrong_done", 32'(w_stall_o), 32'd1);
    dm_store_done_i = 1'b0;
    #1;
    if (w_stall_o) n_stall++;
    tick();
    dm_load_done_i = 1'b1;
    #1;
    check("lb_stall_on_done", 32'(w_stall_o), 32'd0);
    check("lb_stall_cycles", 32'(n_stall), 32'd2);
    tick();
    dm_load_done_i = 1'b0;
    check("lb_ready_back", 32'(e_ready_o), 32'd1);
    check("lb_x_load_clr", 32'(x_load_o), 32'd0);

    // SH 0x2002: upper halfword lanes, data replicated.
    drive_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hAABB_CCDD, 5'd0, 32'h0, 1'b0,
             K_STORE, 4'b1100, 32'hCCDD_CCDD);
    expect_resp("sh");
    tick();
    dm_store_done_i = 1'b1;
    #1;
    check("sh_stall_on_done", 32'(w_stall_o), 32'd0);
    tick();
    dm_store_done_i = 1'b0;
    check("sh_ready_back", 32'(e_ready_o), 32'd1);

    // SB 0x4001 with done in the same cycle as the request pulse.
    drive_op(1'b0, 1'b1, 3'b000, 32'h0000_4001, 32'h1234_56EF, 5'd0, 32'h0, 1'b0,
             K_STORE, 4'b0010, 32'hEFEF_EFEF);
    expect_resp("sb");
    dm_store_done_i = 1'b1;
    #1;
    check("sb_same_cycle_done", 32'(w_stall_o), 32'd0);
    tick();
    dm_store_done_i = 1'b0;
    check("sb_ready_back", 32'(e_ready_o), 32'd1);

    // Misaligned LW and SH are dropped with a one-cycle pulse.
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd4, 32'h0, 1'b0, K_MIS, 4'h0, 32'h0);
    expect_resp("lw_mis");
    tick();
    check("lw_mis_pulse_end", 32'(x_misaligned_o), 32'd0);
    drive_op(1'b0, 1'b1, 3'b001, 32'h0000_2001, 32'h5555_5555, 5'd0, 32'h0, 1'b0, K_MIS, 4'h0, 32'h0);
    expect_resp("sh_mis");
    tick();

    // Load and store both set: treated as load.
    drive_op(1'b1, 1'b1, 3'b010, 32'h0000_7004, 32'h9999_9999, 5'd12, 32'h0, 1'b0,
             K_LOAD, 4'b1111, 32'h0);
    expect_resp("ldst");
    dm_load_done_i = 1'b1;
    tick();
    dm_load_done_i = 1'b0;
    check("ldst_ready_back", 32'(e_ready_o), 32'd1);

    // Load with no done: aborted after four wait cycles.
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd9, 32'h0, 1'b0, K_LOAD, 4'b1111, 32'h0);
    expect_resp("lw_to");
    n_wait = 0;
    while (!e_ready_o && n_wait < 10) begin
      n_wait++;
      tick();
    end
    check("to_wait_cycles", 32'(n_wait), 32'd4);
    check("to_bus_error",   32'(x_bus_error_o), 32'd1);
    check("to_x_load",      32'(x_load_o), 32'd0);
    check("to_rd_write",    32'(x_rd_write_o), 32'd0);
    dm_load_done_i = 1'b1;
    tick();
    dm_load_done_i = 1'b0;
    check("to_pulse_end",   32'(x_bus_error_o), 32'd0);
    check("stray_ready",    32'(e_ready_o), 32'd1);
    check("stray_stall",    32'(w_stall_o), 32'd0);
    check("stray_rd_write", 32'(x_rd_write_o), 32'd0);

    // Reset in WAIT_STORE aborts asynchronously; late done ignored.
    drive_op(1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0,
             K_STORE, 4'b1111, 32'hDEAD_BEEF);
    expect_resp("sw");
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_dm_store", 32'(dm_store_o), 32'd0);
    check("arst_sdata",    dm_data_s_o, 32'd0);
    check("arst_addr",     dm_addr_o, 32'd0);
    check("arst_sel",      32'(dm_data_select_o), 32'd0);
    check("arst_x_addr",   x_dm_addr_o, 32'd0);
    check("arst_ready",    32'(e_ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    dm_store_done_i = 1'b1;
    tick();
    dm_store_done_i = 1'b0;
    check("post_rst_ready", 32'(e_ready_o), 32'd1);
    check("post_rst_stall", 32'(w_stall_o), 32'd0);
    drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd7, 32'hCAFE_F00D, 1'b1, K_ALU, 4'h0, 32'h0);
    expect_resp("alu_post_rst");
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
